deserializador_serie: RTL and testbench

- Downstream stage of the parallel-load serial shift register; consumes its LSB-first serial bitstream and rebuilds BITS-wide words.
- Frames are delimited by a start strobe. Bits are qualified by a bit-enable that mirrors the upstream shift cycles.
- Completed words are presented on a valid/ready output port with a one-word holding buffer.
- A sticky overrun flag is raised when a word completes while the previous word is still unconsumed.

---
 rtl/deserializador_pkg.sv | 23 ++
 rtl/deserializador_serie_contador_bits.sv | 60 ++++++
 rtl/deserializador_serie.sv | 167 ++++++++++++++++
 tb/tb_deserializador_serie.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/deserializador_pkg.sv
// ---------------------------------------------------------------------------
// deserializador_pkg
// Definitions shared by the serial deserializer and its bit counter:
//   - des_state_t : receiver FSM states (IDLE, RECV)
//   - cnt_width() : bit-counter width for a given word width
// ---------------------------------------------------------------------------
package deserializador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } des_state_t;

  // Counter width able to index bits 0..bits-1. It is never narrower than 1 bit.
  function automatic int cnt_width(input int bits);
    if (bits > 1) begin
      return $clog2(bits);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/deserializador_serie_contador_bits.sv
// ---------------------------------------------------------------------------
// contador_bits
// Counts the bits accepted in the current frame. It wraps to 0 after bit BITS-1.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : frame restart. If en is also high, this bit counts as bit 0.
//   en       : a bit is accepted this cycle
//   tc       : terminal count. The next accepted bit is bit BITS-1.
// ---------------------------------------------------------------------------
module contador_bits
  import deserializador_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cnt_width(BITS);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          tc_s;

  assign tc_s = (cnt_r == CW'(BITS - 1));
  assign tc   = tc_s;

  // Next-count selection: a restart has priority over a normal increment.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      if (en) begin
        cnt_next_s = CW'(1);
      end else begin
        cnt_next_s = '0;
      end
    end else if (en) begin
      if (tc_s) begin
        cnt_next_s = '0;
      end else begin
        cnt_next_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/deserializador_serie.sv
// ---------------------------------------------------------------------------
// deserializador_serie
// Rebuilds BITS-wide words from an LSB-first serial stream.
// Frames begin on start, and bits are qualified by bit_en.
// Each completed word goes into a one-word holding buffer with a valid/ready
// handshake. A sticky overrun flag records words dropped because the buffer
// was still full.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : frame start strobe. If bit_en is also high, that bit is bit 0.
//   bit_en   : sin carries a valid bit this cycle
//   sin      : serial data, LSB first
//   ready    : consumer takes dout this cycle
//   clr_ovr  : clears overrun. A new overrun in the same cycle wins.
//   dout     : assembled word (registered)
//   valid    : dout holds an unconsumed word (registered)
//   busy     : frame reception in progress (registered)
//   overrun  : sticky dropped-word flag (registered)
// ---------------------------------------------------------------------------
module deserializador_serie
  import deserializador_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            bit_en,
  input  logic            sin,
  input  logic            ready,
  input  logic            clr_ovr,
  output logic [BITS-1:0] dout,
  output logic            valid,
  output logic            busy,
  output logic            overrun
);

  des_state_t      state_r;
  des_state_t      state_next_s;
  logic            busy_r;
  logic            busy_next_s;
  logic [BITS-1:0] shreg_r;
  logic [BITS-1:0] word_s;
  logic [BITS-1:0] dout_r;
  logic [BITS-1:0] dout_next_s;
  logic            valid_r;
  logic            valid_next_s;
  logic            overrun_r;
  logic            overrun_next_s;
  logic            accept_s;
  logic            tc_s;
  logic            complete_s;
  logic            out_free_s;
  logic            ovr_set_s;

  // A bit counts when a frame is open or is being opened in this same cycle.
  assign accept_s   = bit_en && (start || (state_r == RECV));
  // A start always restarts the frame, so a bit taken with start is never the last bit.
  assign complete_s = accept_s && !start && tc_s;
  // The buffer can take a word if it is empty or is being emptied at this edge.
  assign out_free_s = !valid_r || ready;
  assign ovr_set_s  = complete_s && !out_free_s;
  assign word_s     = {sin, shreg_r[BITS-1:1]};

  contador_bits #(
    .BITS (BITS)
  ) u_contador_bits (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (accept_s),
    .tc  (tc_s)
  );

  // FSM state and busy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // FSM next state. busy is precomputed so that it tracks RECV with no extra delay.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RECV;
        end else begin
          state_next_s = IDLE;
        end
      end
      RECV: begin
        if (start) begin
          state_next_s = RECV;
        end else if (complete_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RECV;
        end
      end
      default: state_next_s = IDLE;
    endcase
    busy_next_s = (state_next_s == RECV);
  end

  // Shift register: new bits enter at the MSB, so the first bit received ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_r <= '0;
    end else if (accept_s) begin
      shreg_r <= word_s;
    end else begin
      shreg_r <= shreg_r;
    end
  end

  // Next value of the holding buffer, the handshake and the overrun flag.
  always_comb begin
    dout_next_s    = dout_r;
    valid_next_s   = valid_r;
    overrun_next_s = overrun_r;
    if (complete_s) begin
      if (out_free_s) begin
        dout_next_s  = word_s;
        valid_next_s = 1'b1;
      end else begin
        dout_next_s  = dout_r;
        valid_next_s = valid_r;
      end
    end else if (valid_r && ready) begin
      valid_next_s = 1'b0;
    end else begin
      valid_next_s = valid_r;
    end
    if (ovr_set_s) begin
      overrun_next_s = 1'b1;
    end else if (clr_ovr) begin
      overrun_next_s = 1'b0;
    end else begin
      overrun_next_s = overrun_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      dout_r    <= dout_next_s;
      valid_r   <= valid_next_s;
      overrun_r <= overrun_next_s;
    end
  end

  assign dout    = dout_r;
  assign valid   = valid_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_deserializador_serie.sv
// ---------------------------------------------------------------------------
// tb_deserializador_serie
// Directed bench for deserializador_serie with BITS=4. Expected values are
// hand-computed constants. Outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_deserializador_serie;

  logic       clk;
  logic       rst;
  logic       start;
  logic       bit_en;
  logic       sin;
  logic       ready;
  logic       clr_ovr;
  logic [3:0] dout;
  logic       valid;
  logic       busy;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  deserializador_serie #(
    .BITS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bit_en  (bit_en),
    .sin     (sin),
    .ready   (ready),
    .clr_ovr (clr_ovr),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, pass one rising edge, and return at the falling edge.
  task automatic cyc(input logic st, input logic be, input logic s,
                     input logic rdy, input logic clr);
    start   = st;
    bit_en  = be;
    sin     = s;
    ready   = rdy;
    clr_ovr = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send a full 4-bit frame LSB first. start is given together with bit 0.
  task automatic frame(input logic [3:0] w, input logic rdy);
    cyc(1'b1, 1'b1, w[0], rdy, 1'b0);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 1'b1, w[i], rdy, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_en = 1'b0; sin = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic word 0xA: bits 0,1,0,1. start arrives together with bit 0.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("basic_busy_b0", 32'(busy), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("basic_valid_pre", 32'(valid), 32'h0);
    chk("basic_busy_b2", 32'(busy), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("basic_valid", 32'(valid), 32'h1);
    chk("basic_dout", 32'(dout), 32'hA);
    chk("basic_busy_end", 32'(busy), 32'h0);
    chk("basic_overrun", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_consumed", 32'(valid), 32'h0);
    chk("basic_dout_hold", 32'(dout), 32'hA);

    // Gapped bits 1,1,0,0. sin=1 on idle cycles must not shift in.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("gap_busy_mid", 32'(busy), 32'h1);
    chk("gap_valid_pre", 32'(valid), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("gap_valid", 32'(valid), 32'h1);
    chk("gap_dout", 32'(dout), 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_consumed", 32'(valid), 32'h0);

    // Backpressure: 0x5 is held while 0xC is dropped and flagged.
    frame(4'h5, 1'b0);
    chk("bp_dout5", 32'(dout), 32'h5);
    chk("bp_valid5", 32'(valid), 32'h1);
    frame(4'hC, 1'b0);
    chk("bp_dout_kept", 32'(dout), 32'h5);
    chk("bp_overrun", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_valid_drop", 32'(valid), 32'h0);
    chk("bp_overrun_sticky", 32'(overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_overrun_clr", 32'(overrun), 32'h0);

    // 0x9 completes on the same edge that 0x1 is consumed.
    frame(4'h1, 1'b0);
    chk("cc_dout1", 32'(dout), 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("cc_dout9", 32'(dout), 32'h9);
    chk("cc_valid", 32'(valid), 32'h1);
    chk("cc_overrun", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("cc_consumed", 32'(valid), 32'h0);

    // Restart mid-frame: the partial 1,1 is discarded and the new word is 1,0,0,0.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rs_busy", 32'(busy), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rs_valid_pre", 32'(valid), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rs_dout", 32'(dout), 32'h1);
    chk("rs_valid", 32'(valid), 32'h1);
    chk("rs_overrun", 32'(overrun), 32'h0);

    // Asynchronous reset between edges, after 2 bits, while a word is still buffered.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ar_busy_pre", 32'(busy), 32'h1);
    chk("ar_valid_pre", 32'(valid), 32'h1);
    start = 1'b0; bit_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_dout", 32'(dout), 32'h0);
    chk("ar_valid", 32'(valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_overrun", 32'(overrun), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    frame(4'h6, 1'b0);
    chk("ar_dout6", 32'(dout), 32'h6);
    chk("ar_valid6", 32'(valid), 32'h1);

    // A set and a clear of overrun on the same edge: the set wins.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sw_overrun", 32'(overrun), 32'h1);
    chk("sw_dout_kept", 32'(dout), 32'h6);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sw_overrun_clr", 32'(overrun), 32'h0);
    chk("sw_valid_drop", 32'(valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
